// File: rtl/ntt_pkg.sv
// Shared NTT constants and modular add/sub helpers.
// Each helper reduces its result with a single conditional correction.
package ntt_pkg;

   localparam int unsigned Q  = 12289;
   localparam int unsigned CW = 14;

   function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b,
                                             input int unsigned    q);
      logic [CW:0] sum;
      logic [CW:0] qw;
      qw  = (CW+1)'(q);
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= qw) begin
         sum = sum - qw;
      end
      return sum[CW-1:0];
   endfunction

   // Borrow out of the extra MSB marks a negative difference.
   function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b,
                                             input int unsigned    q);
      logic [CW:0] diff;
      logic [CW:0] qw;
      qw   = (CW+1)'(q);
      diff = {1'b0, a} - {1'b0, b};
      if (diff[CW]) begin
         diff = diff + qw;
      end
      return diff[CW-1:0];
   endfunction

endpackage

// File: rtl/mod_mul_q.sv
// Combinational Barrett multiply-reduce: p = (a * b) mod Q.
// The 2*CW-bit product is fully reduced within a single cycle.
module mod_mul_q
   import ntt_pkg::*;
#(
   parameter int unsigned Q = ntt_pkg::Q
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   output logic [CW-1:0] p
);

   localparam int unsigned     RW       = CW + 2;
   localparam logic [63:0]     BarrettM = (64'd1 << (2 * CW)) / 64'(Q);
   localparam logic [RW-1:0]   QR       = RW'(Q);

   logic [2*CW-1:0] x;
   logic [63:0]     quot;
   logic [RW-1:0]   r0;
   logic [RW-1:0]   r1;
   logic [RW-1:0]   r2;

   assign x    = a * b;
   assign quot = (64'(x) * BarrettM) >> (2 * CW);

   // True remainder is below 2Q, so a narrow wrap-around subtract is exact.
   assign r0 = RW'(x) - RW'(quot * 64'(Q));
   assign r1 = (r0 >= QR) ? r0 - QR : r0;
   assign r2 = (r1 >= QR) ? r1 - QR : r1;
   assign p  = CW'(r2);

endmodule

// File: rtl/sdf_ntt_stage.sv
// Single-path delay-feedback NTT butterfly stage with a DEPTH-sample span.
// Phase A fills the delay line; phase B emits tops and stores bottoms.
module sdf_ntt_stage
   import ntt_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned Q     = ntt_pkg::Q
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [CW-1:0] in_data,
   input  logic [CW-1:0] tw,
   output logic          out_valid,
   output logic [CW-1:0] out_data,
   output logic          phase
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0] mem [DEPTH];

   // Beat counter doubles as the delay-line pointer; both step and wrap together.
   logic [AW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          primed_q, primed_d;
   logic          out_valid_q, out_valid_d;
   logic [CW-1:0] out_data_q, out_data_d;

   logic [CW-1:0] d;
   logic [CW-1:0] prod;
   logic [CW-1:0] top;
   logic [CW-1:0] bot;
   logic [CW-1:0] wr_data;
   logic          last_beat;

   mod_mul_q #(
      .Q(Q)
   ) u_mul (
      .a(in_data),
      .b(tw),
      .p(prod)
   );

   assign d         = mem[cnt_q];
   assign top       = mod_add(d, prod, Q);
   assign bot       = mod_sub(d, prod, Q);
   assign last_beat = (cnt_q == AW'(DEPTH - 1));
   assign wr_data   = phase_q ? bot : in_data;

   always_comb begin
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      primed_d    = primed_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      if (in_valid) begin
         cnt_d       = last_beat ? '0 : cnt_q + 1'b1;
         out_valid_d = phase_q | primed_q;
         out_data_d  = phase_q ? top : d;
         if (last_beat) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
               primed_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         phase_q     <= 1'b0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Delay line stays unreset so it maps onto RAM; read above is before this write.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         mem[cnt_q] <= wr_data;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign phase     = phase_q;

endmodule
